regfile_wb_arbiter: RTL and testbench

Write-back controller for the 8-entry, 16-bit register file. It shares the file's single write port between two write-back requesters: A for the ALU result and B for the load/memory result. Arbitration is round-robin. It also keeps a busy scoreboard of destination registers reserved by the issue stage and flags read hazards. Its registered write outputs drive the register file's write-enable, write-address and write-data inputs directly; the register file commits on the falling clock edge.

---
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin write-back arbiter with a busy scoreboard for an
//            8-entry register file.
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int ADW  = 3,
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rsv_valid,
    input  logic [ADW-1:0]  rsv_addr,
    output logic            rsv_err,
    input  logic [ADW-1:0]  chk_a1,
    input  logic [ADW-1:0]  chk_a2,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    input  logic            a_req,
    input  logic [ADW-1:0]  a_addr,
    input  logic [DW-1:0]   a_data,
    input  logic            b_req,
    input  logic [ADW-1:0]  b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic            wr_en,
    output logic [ADW-1:0]  wr_addr,
    output logic [DW-1:0]   wr_data
);

    localparam logic C_LAST_A = 1'b0;
    localparam logic C_LAST_B = 1'b1;

    logic            last_q,    last_d;
    logic [NREG-1:0] busy_q,    busy_d;
    logic            rsv_err_q, rsv_err_d;
    logic            wr_en_q,   wr_en_d;
    logic [ADW-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic            w_gnt_any;
    logic [ADW-1:0]  w_gnt_addr;
    logic [DW-1:0]   w_gnt_data;
    logic            w_clr_hit;

    // Contention goes to whichever requester did not win most recently
    always_comb begin
        a_gnt      = a_req & (~b_req | (last_q == C_LAST_B));
        b_gnt      = b_req & (~a_req | (last_q == C_LAST_A));
        w_gnt_any  = a_gnt | b_gnt;
        w_gnt_addr = a_gnt ? a_addr : b_addr;
        w_gnt_data = a_gnt ? a_data : b_data;
    end

    always_comb begin
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_gnt) begin
            last_d = C_LAST_A;
        end else if (b_gnt) begin
            last_d = C_LAST_B;
        end
        // r0 write-backs release the requester but never reach the file
        if (w_gnt_any) begin
            wr_en_d   = (w_gnt_addr != '0);
            wr_addr_d = w_gnt_addr;
            wr_data_d = w_gnt_data;
        end
    end

    always_comb begin
        busy_d    = busy_q;
        rsv_err_d = 1'b0;
        w_clr_hit = w_gnt_any && (w_gnt_addr == rsv_addr);
        if (w_gnt_any) begin
            busy_d[w_gnt_addr] = 1'b0;
        end
        // A reservation applied after the clear wins a same-edge collision
        if (rsv_valid && (rsv_addr != '0)) begin
            if (busy_q[rsv_addr] && !w_clr_hit) begin
                rsv_err_d = 1'b1;
            end
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q    <= C_LAST_B;
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            last_q    <= last_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign hazard  = busy_q[chk_a1] | busy_q[chk_a2];
    assign busy    = busy_q;
    assign rsv_err = rsv_err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed and randomized checks of regfile_wb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rsv_valid;
    logic [2:0]  rsv_addr;
    logic        rsv_err;
    logic [2:0]  chk_a1, chk_a2;
    logic        hazard;
    logic [7:0]  busy;
    logic        a_req, b_req;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_gnt, b_gnt;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: who won last, which registers are reserved, what was issued
    bit          m_last_is_b;
    bit          m_busy [8];
    bit          m_wr_en;
    bit [2:0]    m_wr_addr;
    bit [15:0]   m_wr_data;
    bit          m_err;
    bit          e_a, e_b;

    regfile_wb_arbiter #(.ADW(3), .DW(16), .NREG(8)) dut (
        .clk(clk), .rstn(rstn),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard), .busy(busy),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] model_busy_vec();
        bit [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last_is_b = 1'b1;
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_err = 0;
        e_a = 0; e_b = 0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        bit       win_a, any;
        bit [2:0] ga;
        bit [15:0] gd;
        bit       was_busy;
        #1;
        if (a_req && b_req) begin
            e_a = m_last_is_b; e_b = !m_last_is_b;
        end else begin
            e_a = a_req; e_b = b_req;
        end
        check("a_gnt", a_gnt, e_a);
        check("b_gnt", b_gnt, e_b);
        check("hazard", hazard, m_busy[chk_a1] | m_busy[chk_a2]);
        @(posedge clk);
        win_a = e_a;
        any   = e_a | e_b;
        ga    = win_a ? a_addr : b_addr;
        gd    = win_a ? a_data : b_data;
        was_busy = m_busy[rsv_addr];
        m_err = 0;
        if (any) begin
            m_last_is_b = !win_a;
            m_wr_en   = (ga != 0);
            m_wr_addr = ga;
            m_wr_data = gd;
            m_busy[ga] = 0;
        end else begin
            m_wr_en = 0;
        end
        if (rsv_valid && rsv_addr != 0) begin
            if (was_busy && !(any && ga == rsv_addr)) m_err = 1;
            m_busy[rsv_addr] = 1;
        end
        #1;
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
        check("busy", busy, model_busy_vec());
        check("rsv_err", rsv_err, m_err);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rsv_valid = 0; rsv_addr = 0; chk_a1 = 0; chk_a2 = 0;
        a_req = 0; a_addr = 0; a_data = 0;
        b_req = 0; b_addr = 0; b_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rstn = 1;
    endtask

    initial begin
        rstn = 1;
        idle_inputs();
        model_reset();
        do_reset();

        // Reset state then idle
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 8'h00);
        check("rst_err", rsv_err, 0);
        repeat (5) step();

        // Contention: A first after reset, then alternating
        a_req = 1; a_addr = 3'd1; a_data = 16'h1111;
        b_req = 1; b_addr = 3'd2; b_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cont_addr", wr_addr, (i % 2 == 0) ? 1 : 2);
            check("cont_data", wr_data, (i % 2 == 0) ? 16'h1111 : 16'h2222);
        end
        idle_inputs();

        // Scoreboard round trip on r3
        rsv_valid = 1; rsv_addr = 3'd3;
        step();
        rsv_valid = 0; chk_a1 = 3'd3;
        #1 check("rt_hazard_set", hazard, 1);
        a_req = 1; a_addr = 3'd3; a_data = 16'hBEEF;
        step();
        a_req = 0;
        check("rt_wr_en", wr_en, 1);
        check("rt_wr_addr", wr_addr, 3);
        check("rt_wr_data", wr_data, 16'hBEEF);
        check("rt_busy3", busy[3], 0);
        #1 check("rt_hazard_clr", hazard, 0);
        idle_inputs();

        // Same-edge clear and set of r5
        rsv_valid = 1; rsv_addr = 3'd5;
        step();
        b_req = 1; b_addr = 3'd5; b_data = 16'h5555;
        step();
        check("same_busy5", busy[5], 1);
        check("same_err", rsv_err, 0);
        b_req = 0;
        step();
        check("dup_err", rsv_err, 1);
        rsv_valid = 0;
        step();
        check("dup_err_pulse", rsv_err, 0);

        // r0 protection
        rsv_valid = 1; rsv_addr = 3'd0;
        a_req = 1; a_addr = 3'd0; a_data = 16'hFFFF;
        #1 check("r0_gnt", a_gnt, 1);
        step();
        check("r0_wr_en", wr_en, 0);
        check("r0_busy0", busy[0], 0);
        check("r0_err", rsv_err, 0);
        idle_inputs();

        // Async reset mid-stream with last = A
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            rsv_valid = 1; rsv_addr = r[2:0];
            step();
        end
        rsv_valid = 0;
        check("pre_rst_busy", busy, 8'h0E);
        a_req = 1; a_addr = 3'd4; a_data = 16'h4444;
        step();
        b_req = 1; b_addr = 3'd6; b_data = 16'h6666;
        #2 rstn = 0;
        #1;
        check("arst_busy", busy, 8'h00);
        check("arst_wr_en", wr_en, 0);
        model_reset();
        @(negedge clk);
        rstn = 1;
        step();
        check("arst_first_a", wr_addr, 4);

        // Randomized traffic with requesters that hold until granted
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!a_req || e_a) begin
                a_req  = ($urandom_range(0, 2) != 0);
                a_addr = 3'($urandom_range(0, 7));
                a_data = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                a_req = 0;
            end
            if (!b_req || e_b) begin
                b_req  = ($urandom_range(0, 2) != 0);
                b_addr = 3'($urandom_range(0, 7));
                b_data = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                b_req = 0;
            end
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_addr  = 3'($urandom_range(0, 7));
            chk_a1    = 3'($urandom_range(0, 7));
            chk_a2    = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
